// File: rtl/phase_serial_receiver.sv
// phase_serial_receiver
//   Receive end of the phase detector serial link. Deserializes an SPI-style stream
//   (serial_clk / serial_ss_n / serial_data, all asynchronous to sys_clk) into DATA_WIDTH-bit
//   words, MSB first, and presents them through a valid/ready holding register.
//
// Ports
//   sys_clk      in   receive clock, at least 4x serial_clk
//   rst_n        in   asynchronous active-low reset (release synchronized internally)
//   serial_clk   in   link clock, data sampled on its rising edge
//   serial_ss_n  in   frame select, active low
//   serial_data  in   link data
//   data_out     out  last accepted word
//   phase_field  out  data_out[PHASE_BITS-1:0]
//   clock_field  out  data_out[DATA_WIDTH-1:PHASE_BITS]
//   data_valid   out  data_out holds an unconsumed word
//   data_ready   in   consumer takes the word when data_valid & data_ready
//   frame_err    out  1-cycle pulse: short frame or extra serial_clk edges
//   overflow     out  1-cycle pulse: completed word dropped because holding reg was full
module phase_serial_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int PHASE_BITS  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic                           serial_clk,
    input  logic                           serial_ss_n,
    input  logic                           serial_data,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [PHASE_BITS-1:0]          phase_field,
    output logic [DATA_WIDTH-PHASE_BITS-1:0] clock_field,
    output logic                           data_valid,
    input  logic                           data_ready,
    output logic                           frame_err,
    output logic                           overflow
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DATA_WIDTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT    = 2'd1;
    localparam logic [1:0] WAIT_END = 2'd2;

    // Reset: asserts asynchronously, releases on a sys_clk edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // Input synchronizers, preset to the idle line levels.
    logic [SYNC_STAGES-1:0] ss_sync, clk_sync, data_sync;
    logic                   ss_prev, clk_prev;

    always_ff @(posedge sys_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ss_sync   <= {SYNC_STAGES{1'b1}};
            clk_sync  <= '0;
            data_sync <= '0;
            ss_prev   <= 1'b1;
            clk_prev  <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], serial_ss_n};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], serial_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], serial_data};
            ss_prev   <= ss_sync[SYNC_STAGES-1];
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    logic ss_s, data_s, ss_fall, ss_rise, clk_rise;
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign ss_fall  = !ss_s && ss_prev;
    assign ss_rise  = ss_s && !ss_prev;
    assign clk_rise = clk_sync[SYNC_STAGES-1] && !clk_prev;

    // Frame FSM
    logic [1:0]            state, state_n;
    logic [CW-1:0]         count, count_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic                  done, done_n;
    logic                  err_seen, err_seen_n;
    logic                  err_n;

    always_comb begin
        state_n    = state;
        count_n    = count;
        shift_n    = shift_reg;
        done_n     = 1'b0;
        err_seen_n = err_seen;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n    = SHIFT;
                    count_n    = '0;
                    shift_n    = '0;
                    err_seen_n = 1'b0;
                end
            end
            SHIFT: begin
                // Deselect wins over a coincident clock edge: ss_n high means edges are ignored.
                if (ss_rise) begin
                    state_n = IDLE;
                    err_n   = (count != '0);
                end else if (clk_rise) begin
                    shift_n = {shift_reg[DATA_WIDTH-2:0], data_s};
                    if (count == LAST_BIT) begin
                        state_n = WAIT_END;
                        count_n = FULL;
                        done_n  = 1'b1;
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end
            WAIT_END: begin
                if (ss_rise) begin
                    state_n = IDLE;
                end else if (clk_rise && !err_seen) begin
                    err_n      = 1'b1;
                    err_seen_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Holding register: a completed word loads if the slot is empty or is being drained.
    logic load;
    assign load = done && (!data_valid || data_ready);

    always_ff @(posedge sys_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            count      <= '0;
            shift_reg  <= '0;
            done       <= 1'b0;
            err_seen   <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            shift_reg <= shift_n;
            done      <= done_n;
            err_seen  <= err_seen_n;
            frame_err <= err_n;
            overflow  <= done && !load;
            if (load) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign phase_field = data_out[PHASE_BITS-1:0];
    assign clock_field = data_out[DATA_WIDTH-1:PHASE_BITS];

endmodule

// File: tb/tb_phase_serial_receiver.sv
module tb_phase_serial_receiver;

    localparam int SYNC_STAGES = 2;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_clk = 1'b0;
    logic       serial_ss_n = 1'b1;
    logic       serial_data = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic [4:0] phase_field;
    logic [2:0] clock_field;
    logic       data_valid, frame_err, overflow;

    phase_serial_receiver #(
        .DATA_WIDTH (8),
        .PHASE_BITS (5),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .serial_clk (serial_clk),
        .serial_ss_n(serial_ss_n),
        .serial_data(serial_data),
        .data_out   (data_out),
        .phase_field(phase_field),
        .clock_field(clock_field),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] word;
        logic [2:0] clk_f;
        logic [4:0] ph_f;
    } vec_t;

    vec_t vec[8];
    vec_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt = 0;
    int   err_cnt = 0;
    int   ovf_cnt = 0;
    event lsb_rise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge sys_clk) begin
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
        if (data_valid && data_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got word %0h, expected none", data_out);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("sb_data", data_out, e.word);
                check("sb_clock_field", clock_field, e.clk_f);
                check("sb_phase_field", phase_field, e.ph_f);
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    // Sends bits[n-1:0] MSB first; 3 sys_clk cycles per serial_clk half period.
    task automatic send_bits(input logic [15:0] bits, input int n, input bit end_frame);
        step();
        serial_ss_n = 1'b0;
        repeat (3) step();
        for (int i = n - 1; i >= 0; i--) begin
            serial_data = bits[i];
            repeat (3) step();
            serial_clk = 1'b1;
            if (i == 0) ->lsb_rise;
            repeat (3) step();
            serial_clk = 1'b0;
        end
        if (end_frame) begin
            repeat (3) step();
            serial_ss_n = 1'b1;
            repeat (6) step();
        end
    endtask

    task automatic drain();
        data_ready = 1'b1;
        repeat (2) step();
        data_ready = 1'b0;
        step();
    endtask

    int e0, o0;

    initial begin
        vec[0] = '{8'hA5, 3'd5, 5'h05};
        vec[1] = '{8'h3C, 3'd1, 5'h1C};
        vec[2] = '{8'h01, 3'd0, 5'h01};
        vec[3] = '{8'hFF, 3'd7, 5'h1F};
        vec[4] = '{8'h5A, 3'd2, 5'h1A};
        vec[5] = '{8'hC3, 3'd6, 5'h03};
        vec[6] = '{8'h7E, 3'd3, 5'h1E};
        vec[7] = '{8'h11, 3'd0, 5'h11};

        #3;
        check("reset_data", data_out, 8'h00);
        check("reset_valid", data_valid, 1'b0);
        check("reset_err", frame_err, 1'b0);
        check("reset_ovf", overflow, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (5) step();

        // 1: 0xA5 held until ready, latency SYNC_STAGES+2
        sb.push_back(vec[0]);
        fork
            send_bits({8'h00, 8'hA5}, 8, 1'b1);
            begin
                @(lsb_rise);
                repeat (SYNC_STAGES + 1) @(posedge sys_clk);
                @(negedge sys_clk);
                check("t1_latency_early", data_valid, 1'b0);
                @(negedge sys_clk);
                check("t1_latency_valid", data_valid, 1'b1);
            end
        join
        repeat (10) step();
        check("t1_held_valid", data_valid, 1'b1);
        check("t1_held_data", data_out, 8'hA5);
        check("t1_clock_field", clock_field, 3'b101);
        check("t1_phase_field", phase_field, 5'h05);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        @(negedge sys_clk);
        check("t1_valid_cleared", data_valid, 1'b0);

        // Table: each vector with ready held high
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(vec[i]);
            send_bits({8'h00, vec[i].word}, 8, 1'b1);
        end
        repeat (3) step();
        data_ready = 1'b0;
        step();
        check("table_drained", sb.size(), 0);

        // 2: short frame then 0x3C
        e0 = err_cnt;
        send_bits(16'h0005, 3, 1'b1);
        check("t2_err_pulse", err_cnt - e0, 1);
        check("t2_no_valid", data_valid, 1'b0);
        data_ready = 1'b1;
        sb.push_back(vec[1]);
        send_bits({8'h00, 8'h3C}, 8, 1'b1);
        repeat (2) step();
        data_ready = 1'b0;
        check("t2_err_total", err_cnt - e0, 1);

        // 3: overflow keeps old word
        o0 = ovf_cnt;
        sb.push_back(vec[2]);
        send_bits({8'h00, 8'h01}, 8, 1'b1);
        send_bits({8'h00, 8'hFF}, 8, 1'b1);
        check("t3_ovf_pulse", ovf_cnt - o0, 1);
        check("t3_data_kept", data_out, 8'h01);
        check("t3_valid", data_valid, 1'b1);
        drain();

        // 4: ready in the very cycle the next word loads
        o0 = ovf_cnt;
        sb.push_back(vec[7]);
        send_bits({8'h00, 8'h11}, 8, 1'b1);
        sb.push_back(vec[4]);
        fork
            send_bits({8'h00, 8'h5A}, 8, 1'b1);
            begin
                @(lsb_rise);
                repeat (SYNC_STAGES + 1) @(posedge sys_clk);
                #2 data_ready = 1'b1;
                @(posedge sys_clk);
                #2 data_ready = 1'b0;
            end
        join
        check("t4_no_ovf", ovf_cnt - o0, 0);
        check("t4_data", data_out, 8'h5A);
        check("t4_valid", data_valid, 1'b1);
        drain();

        // 5: 10 edges in one frame
        e0 = err_cnt;
        data_ready = 1'b1;
        sb.push_back(vec[5]);
        send_bits({6'b0, 8'hC3, 2'b10}, 10, 1'b1);
        repeat (2) step();
        data_ready = 1'b0;
        check("t5_err_once", err_cnt - e0, 1);
        check("t5_data", data_out, 8'hC3);

        // 6: reset mid-frame
        e0 = err_cnt;
        send_bits({8'h00, 8'h42}, 8, 1'b1);
        check("t6_pre_data", data_out, 8'h42);
        send_bits(16'h0009, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", data_out, 8'h00);
        check("t6_rst_valid", data_valid, 1'b0);
        check("t6_rst_fields", {clock_field, phase_field}, 8'h00);
        check("t6_rst_pulses", {frame_err, overflow}, 2'b00);
        serial_ss_n = 1'b1;
        serial_clk  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        data_ready = 1'b1;
        sb.push_back(vec[6]);
        send_bits({8'h00, 8'h7E}, 8, 1'b1);
        repeat (2) step();
        data_ready = 1'b0;
        check("t6_no_err", err_cnt - e0, 0);
        check("t6_data", data_out, 8'h7E);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
